// File: rtl/ramp_signal_analyzer.sv
// ramp_signal_analyzer: follows an 8-bit 0..RAMP_LEN-1 ramp stream, acquires lock,
// counts sequence errors while locked, measures the ramp period in valid samples
// and pulses on every wrap seen while locked.
module ramp_signal_analyzer #(
    parameter int unsigned RAMP_LEN    = 40,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned UNLOCK_ERRS = 3
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic [7:0]  sample_in,
    input  logic        sample_valid,
    output logic        locked,
    output logic [15:0] err_count,
    output logic [7:0]  period,
    output logic        wrap_pulse
);

    typedef enum logic [1:0] {
        StHunt,
        StAcquire,
        StLocked
    } state_e;

    localparam logic [7:0] LastVal   = 8'(RAMP_LEN - 1);
    localparam logic [3:0] LockCnt   = 4'(LOCK_COUNT);
    localparam logic [3:0] UnlockCnt = 4'(UNLOCK_ERRS);

    state_e      state_q, state_d;
    logic [7:0]  prev_q, prev_d;
    logic [3:0]  match_cnt_q, match_cnt_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic [7:0]  per_cnt_q, per_cnt_d;
    logic        first_wrap_q, first_wrap_d;
    logic [15:0] err_count_q, err_count_d;
    logic [7:0]  period_q, period_d;
    logic        wrap_pulse_q, wrap_pulse_d;
    logic        locked_q, locked_d;

    logic [7:0]  expected;
    logic        is_match;

    // Successor check; an out-of-range value on either side can never match,
    // so a bad sample and the one after it both count as mismatches.
    always_comb begin
        expected = (prev_q == LastVal) ? 8'd0 : prev_q + 8'd1;
        is_match = (prev_q <= LastVal) && (sample_in <= LastVal) && (sample_in == expected);
    end

    // Next-state logic: FSM, lock/miss counters, error count and period capture.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        per_cnt_d    = per_cnt_q;
        first_wrap_d = first_wrap_q;
        err_count_d  = err_count_q;
        period_d     = period_q;
        wrap_pulse_d = 1'b0;

        if (sample_valid) begin
            // prev always resyncs to the latest sample, match or not
            prev_d    = sample_in;
            per_cnt_d = (per_cnt_q == 8'hFF) ? per_cnt_q : per_cnt_q + 8'd1;

            case (state_q)
                StHunt: begin
                    state_d     = StAcquire;
                    match_cnt_d = 4'd0;
                end
                StAcquire: begin
                    if (is_match) begin
                        if (match_cnt_q + 4'd1 == LockCnt) begin
                            state_d     = StLocked;
                            match_cnt_d = 4'd0;
                            miss_cnt_d  = 4'd0;
                        end else begin
                            match_cnt_d = match_cnt_q + 4'd1;
                        end
                    end else begin
                        match_cnt_d = 4'd0;
                    end
                end
                StLocked: begin
                    if (is_match) begin
                        miss_cnt_d = 4'd0;
                        if (sample_in == 8'd0) begin
                            wrap_pulse_d = 1'b1;
                            per_cnt_d    = 8'd1;
                            // The first wrap after lock only arms the measurement
                            if (first_wrap_q) begin
                                period_d = per_cnt_q;
                            end
                            first_wrap_d = 1'b1;
                        end
                    end else begin
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        if (miss_cnt_q + 4'd1 == UnlockCnt) begin
                            state_d      = StHunt;
                            miss_cnt_d   = 4'd0;
                            match_cnt_d  = 4'd0;
                            first_wrap_d = 1'b0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end

        locked_d = (state_d == StLocked);
    end

    // State and output registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StHunt;
            prev_q       <= 8'd0;
            match_cnt_q  <= 4'd0;
            miss_cnt_q   <= 4'd0;
            per_cnt_q    <= 8'd0;
            first_wrap_q <= 1'b0;
            err_count_q  <= 16'd0;
            period_q     <= 8'd0;
            wrap_pulse_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            per_cnt_q    <= per_cnt_d;
            first_wrap_q <= first_wrap_d;
            err_count_q  <= err_count_d;
            period_q     <= period_d;
            wrap_pulse_q <= wrap_pulse_d;
            locked_q     <= locked_d;
        end
    end

    assign locked     = locked_q;
    assign err_count  = err_count_q;
    assign period     = period_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_ramp_signal_analyzer.sv
// Testbench for ramp_signal_analyzer: directed test-plan scenarios plus a random
// stream, all checked by a queue scoreboard fed from a behavioural model.
module tb_ramp_signal_analyzer;

    localparam int RampLen    = 40;
    localparam int LockCount  = 4;
    localparam int UnlockErrs = 3;

    logic        clk1;
    logic        rst_n;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic        locked;
    logic [15:0] err_count;
    logic [7:0]  period;
    logic        wrap_pulse;

    ramp_signal_analyzer #(
        .RAMP_LEN   (RampLen),
        .LOCK_COUNT (LockCount),
        .UNLOCK_ERRS(UnlockErrs)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .locked      (locked),
        .err_count   (err_count),
        .period      (period),
        .wrap_pulse  (wrap_pulse)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        int lk;
        int err;
        int per;
        int wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: lock is a run of good successor pairs after a hunt sample,
    // period is the valid-sample distance between the last two wraps since lock.
    bit m_locked;
    bit m_need_hunt;
    int m_run;
    int m_bad;
    int m_err;
    int m_period;
    int m_idx;
    int m_prev;
    bit m_wrap;
    int wraps[$];

    bit gap_en;
    int gcnt;

    function automatic bit succ(int p, int s);
        return (p < RampLen) && (s < RampLen) && (s == (p + 1) % RampLen);
    endfunction

    function automatic void model_reset();
        m_locked    = 1'b0;
        m_need_hunt = 1'b1;
        m_run       = 0;
        m_bad       = 0;
        m_err       = 0;
        m_period    = 0;
        m_idx       = 0;
        m_prev      = 0;
        m_wrap      = 1'b0;
        wraps.delete();
    endfunction

    function automatic void model_step(bit v, int s);
        int d;
        m_wrap = 1'b0;
        if (!v) return;
        m_idx++;
        if (m_need_hunt) begin
            m_need_hunt = 1'b0;
            m_run       = 0;
        end else if (!m_locked) begin
            if (succ(m_prev, s)) begin
                m_run++;
                if (m_run == LockCount) begin
                    m_locked = 1'b1;
                    m_bad    = 0;
                    wraps.delete();
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (succ(m_prev, s)) begin
                m_bad = 0;
                if (s == 0) begin
                    m_wrap = 1'b1;
                    wraps.push_back(m_idx);
                    if (wraps.size() >= 2) begin
                        d = wraps[wraps.size()-1] - wraps[wraps.size()-2];
                        m_period = (d > 255) ? 255 : d;
                    end
                end
            end else begin
                if (m_err < 65535) m_err++;
                m_bad++;
                if (m_bad == UnlockErrs) begin
                    m_locked    = 1'b0;
                    m_need_hunt = 1'b1;
                end
            end
        end
        m_prev = s;
    endfunction

    task automatic cmp(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle at the falling edge and queue the expected post-edge outputs.
    task automatic cycle(input bit v, input int s);
        exp_t e;
        @(negedge clk1);
        sample_valid = v;
        sample_in    = 8'(s);
        model_step(v, s);
        e.lk   = m_locked;
        e.err  = m_err;
        e.per  = m_period;
        e.wrap = m_wrap;
        exp_q.push_back(e);
    endtask

    task automatic send(input int s);
        while (gap_en && (gcnt % 7) >= 4) begin
            cycle(1'b0, 0);
            gcnt++;
        end
        cycle(1'b1, s);
        gcnt++;
    endtask

    task automatic ramp(input int start, input int n);
        for (int i = 0; i < n; i++) send((start + i) % RampLen);
    endtask

    task automatic settle();
        @(posedge clk1);
        #2;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk1);
        sample_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        cmp("rst_locked", locked, 0);
        cmp("rst_err", err_count, 0);
        cmp("rst_period", period, 0);
        cmp("rst_wrap", wrap_pulse, 0);
        @(negedge clk1);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: pops one expected record per clock edge and compares.
    always begin : monitor
        exp_t e;
        @(posedge clk1);
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("locked", locked, e.lk);
            cmp("err_count", err_count, e.err);
            cmp("period", period, e.per);
            cmp("wrap_pulse", wrap_pulse, e.wrap);
        end
    end

    initial begin
        int last;
        int r;
        int v;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 8'd0;
        gap_en       = 1'b0;
        gcnt         = 0;
        model_reset();
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;

        // Continuous ramp from reset: lock after sample 4, wraps at 40 and 80
        ramp(0, 86);
        settle();
        cmp("ramp_period", period, 40);
        cmp("ramp_err", err_count, 0);
        cmp("ramp_locked", locked, 1);

        // Same ramp with valid low 3 of every 7 cycles
        do_reset();
        gap_en = 1'b1;
        ramp(0, 86);
        gap_en = 1'b0;
        settle();
        cmp("gap_period", period, 40);
        cmp("gap_err", err_count, 0);
        cmp("gap_locked", locked, 1);

        // Single bad value: ...10,99,12... costs two errors, lock holds
        ramp(6, 5);
        send(99);
        ramp(12, 8);
        settle();
        cmp("inj_err", err_count, 2);
        cmp("inj_locked", locked, 1);

        // Three consecutive bad values drop lock
        send(200);
        send(201);
        send(200);
        settle();
        cmp("unlock_locked", locked, 0);
        cmp("unlock_err", err_count, 5);

        // Clean ramp relocks after 5 valid samples, period holds until two wraps
        ramp(0, 5);
        settle();
        cmp("relock_locked", locked, 1);
        cmp("relock_period", period, 40);
        ramp(5, 40);
        settle();
        cmp("hold_period", period, 40);

        // Reset while locked with err_count=5
        do_reset();
        ramp(0, 4);
        settle();
        cmp("post_rst_unlocked", locked, 0);
        ramp(4, 1);
        settle();
        cmp("post_rst_locked", locked, 1);

        // Mid-ramp start at 37: lock on sample 1, period after second wrap
        do_reset();
        send(37);
        send(38);
        send(39);
        send(0);
        send(1);
        settle();
        cmp("mid_locked", locked, 1);
        cmp("mid_period0", period, 0);
        ramp(2, 39);
        settle();
        cmp("mid_period_armed", period, 0);
        ramp(1, 40);
        settle();
        cmp("mid_period", period, 40);

        // Random stream: mostly ramp, with gaps, glitches and out-of-range values
        do_reset();
        last = 0;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                cycle(1'b0, int'($urandom_range(0, 255)));
            end else begin
                if (r < 20) v = int'($urandom_range(0, 255));
                else if (r < 23) v = int'($urandom_range(0, RampLen - 1));
                else v = (last + 1) % RampLen;
                cycle(1'b1, v);
                last = (v < RampLen) ? v : RampLen - 1;
            end
        end
        cycle(1'b0, 0);
        settle();
        cmp("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
